// File: rtl/delay_sum_beamformer.sv
// rtl/delay_sum_beamformer.sv - four-channel delay-and-sum beamformer with per-channel history
module delay_sum_beamformer #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int DLY_W = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             newSample,
    input  logic [DW-1:0]    ch0,
    input  logic [DW-1:0]    ch1,
    input  logic [DW-1:0]    ch2,
    input  logic [DW-1:0]    ch3,
    input  logic [DLY_W-1:0] dly0,
    input  logic [DLY_W-1:0] dly1,
    input  logic [DLY_W-1:0] dly2,
    input  logic [DLY_W-1:0] dly3,
    output logic [DW+1:0]    beam,
    output logic             beam_valid,
    output logic             overrun
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t           state_q;
    logic             s1_q, s2_q, s3_q;
    logic             cap;
    logic [DW-1:0]    ch_in    [4];
    logic [DLY_W-1:0] dly_in   [4];
    logic [DW-1:0]    sh_ch_q  [4];
    logic [DLY_W-1:0] sh_dly_q [4];
    logic [DW-1:0]    hist_q   [4][DEPTH];
    logic [DLY_W-1:0] wr_ptr_q;
    logic [1:0]       k_q;
    logic [DW+1:0]    acc_q, acc_d;
    logic [DW+1:0]    beam_q;
    logic             beam_valid_q, overrun_q;
    logic [DLY_W-1:0] rd_addr;
    logic [DW-1:0]    rd_data;

    assign ch_in[0]  = ch0;
    assign ch_in[1]  = ch1;
    assign ch_in[2]  = ch2;
    assign ch_in[3]  = ch3;
    assign dly_in[0] = dly0;
    assign dly_in[1] = dly1;
    assign dly_in[2] = dly2;
    assign dly_in[3] = dly3;

    assign cap        = s2_q & ~s3_q;
    assign beam       = beam_q;
    assign beam_valid = beam_valid_q;
    assign overrun    = overrun_q;

    // Pointer subtraction in DLY_W bits gives the modulo-DEPTH wrap for free.
    always_comb begin
        rd_addr = wr_ptr_q - sh_dly_q[k_q];
        rd_data = hist_q[k_q][rd_addr];
        acc_d   = acc_q + {2'b00, rd_data};
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            beam_q       <= '0;
            beam_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sh_ch_q[i]  <= '0;
                sh_dly_q[i] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    hist_q[i][j] <= '0;
                end
            end
        end else begin
            s1_q         <= newSample;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            beam_valid_q <= 1'b0;
            if (cap && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (cap) begin
                        for (int i = 0; i < 4; i++) begin
                            sh_ch_q[i]  <= ch_in[i];
                            sh_dly_q[i] <= dly_in[i];
                        end
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    for (int i = 0; i < 4; i++) begin
                        hist_q[i][wr_ptr_q] <= sh_ch_q[i];
                    end
                    acc_q   <= '0;
                    k_q     <= '0;
                    state_q <= READ;
                end
                READ: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 2'd1;
                    // Result is published on entry to DONE so beam_valid lands on edge 8.
                    if (k_q == 2'd3) begin
                        beam_q       <= acc_d;
                        beam_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    wr_ptr_q <= wr_ptr_q + DLY_W'(1);
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
